// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch path: fetch FSM states,
// address/width constants and the boot-byte packing helper.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          PC_W       = 8;
    localparam int          IMEM_DEPTH = 64;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    // Lane 0 is the most significant byte: boot words arrive big-endian.
    function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                              input logic [7:0]  data,
                                              input logic [1:0]  lane);
        return word | ({data, 24'h00_0000} >> {lane, 3'b000});
    endfunction

endpackage

// File: rtl/imem_boot_fetch_if.sv
// Fetch-stage bus: PC in, instruction out, plus the boot-loader byte stream
// and run/status flags. The core side uses master, the fetch block slave.
interface imem_boot_fetch_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) ();

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload;
    logic              cpu_run;
    logic [CNT_W-1:0]  words_loaded;
    logic              fetch_err;

    modport master (
        output pc, load_valid, load_data, load_last, reload,
        input  instr, load_ready, cpu_run, words_loaded, fetch_err
    );

    modport slave (
        input  pc, load_valid, load_data, load_last, reload,
        output instr, load_ready, cpu_run, words_loaded, fetch_err
    );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, asynchronous read, no reset.
// Stale contents are harmless because reads are masked by the word count.
module imem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Word write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_boot_fetch.sv
// Instruction fetch with boot loader: packs a big-endian byte stream into
// the instruction array, then serves pc-addressed words while cpu_run is high.
module imem_boot_fetch
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_boot_fetch_if.slave bus
);

    localparam int                AW        = $clog2(DEPTH);
    localparam int                PTR_W     = AW + 1;
    localparam logic [PTR_W-1:0]  PTR_FULL  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [1:0]        BYTE_LAST = 2'd3;

    fetch_state_t      state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic              fetch_err_q, fetch_err_d;

    logic              we_s;
    logic [DATA_W-1:0] pack_word_s;
    logic [AW-1:0]     rd_idx_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              in_range_s;
    logic              aligned_s;
    logic [DATA_W-1:0] instr_s;

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (pack_word_s),
        .raddr_i (rd_idx_s),
        .rdata_o (rd_data_s)
    );

    // Partial word plus the incoming byte; low lanes not yet filled stay zero.
    assign pack_word_s = pack_byte(pack_q, bus.load_data, byte_cnt_q);
    assign rd_idx_s    = bus.pc[PC_W-1:2];
    assign aligned_s   = (bus.pc[1:0] == 2'b00);
    assign in_range_s  = ({1'b0, rd_idx_s} < wr_ptr_q);

    // State, pointer, packer and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            byte_cnt_q  <= 2'd0;
            pack_q      <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            pack_q      <= pack_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Next-state logic: byte acceptance in LOAD, alignment and reload in RUN
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        fetch_err_d = fetch_err_q;
        we_s        = 1'b0;

        case (state_q)
            LOAD: begin
                if (bus.load_valid) begin
                    if (wr_ptr_q == PTR_FULL) begin
                        state_d     = ERR;
                        fetch_err_d = 1'b1;
                    end else if (bus.load_last || (byte_cnt_q == BYTE_LAST)) begin
                        we_s       = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        byte_cnt_d = 2'd0;
                        pack_d     = '0;
                        if (bus.load_last) begin
                            state_d = RUN;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        pack_d     = pack_word_s;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = LOAD;
                end
            end

            RUN: begin
                // reload has priority over a misaligned pc in the same cycle
                if (bus.reload) begin
                    state_d     = LOAD;
                    wr_ptr_d    = '0;
                    byte_cnt_d  = 2'd0;
                    pack_d      = '0;
                    fetch_err_d = 1'b0;
                end else if (!aligned_s) begin
                    fetch_err_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d     = ERR;
                fetch_err_d = 1'b1;
            end
        endcase
    end

    // Fetch mux: only aligned, loaded words are visible, and only in RUN
    always_comb begin
        instr_s = NOP_INSTR;
        if ((state_q == RUN) && aligned_s && in_range_s) begin
            instr_s = rd_data_s;
        end else begin
            instr_s = NOP_INSTR;
        end
    end

    assign bus.instr        = instr_s;
    assign bus.load_ready   = (state_q == LOAD);
    assign bus.cpu_run      = (state_q == RUN);
    assign bus.words_loaded = wr_ptr_q;
    assign bus.fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Directed bench for imem_boot_fetch: a word-level reference model checked
// every cycle, plus literal expectations taken from the worked examples.
module tb_imem_boot_fetch;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    bit   check_en = 1'b0;

    imem_boot_fetch_if bus ();

    imem_boot_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = loading, 1 = running, 2 = error
    int          m_mode  = 0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    logic [31:0] m_mem [64];
    logic [7:0]  m_bytes [$];

    task automatic model_step();
        logic [31:0] w;
        if (!rst_n) begin
            m_mode  = 0;
            m_count = 0;
            m_err   = 1'b0;
            m_bytes.delete();
        end else if (m_mode == 0) begin
            if (bus.load_valid) begin
                if (m_count == 64) begin
                    m_mode = 2;
                    m_err  = 1'b1;
                end else begin
                    m_bytes.push_back(bus.load_data);
                    if (m_bytes.size() == 4 || bus.load_last) begin
                        w = 32'h0;
                        for (int i = 0; i < m_bytes.size(); i++)
                            w = w | (32'(m_bytes[i]) << (24 - 8 * i));
                        m_mem[m_count] = w;
                        m_count++;
                        m_bytes.delete();
                        if (bus.load_last) m_mode = 1;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (bus.reload) begin
                m_mode  = 0;
                m_count = 0;
                m_err   = 1'b0;
                m_bytes.delete();
            end else if (bus.pc % 4 != 0) begin
                m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] model_instr();
        int idx;
        idx = int'(bus.pc) / 4;
        if (m_mode == 1 && (bus.pc % 4 == 0) && idx < m_count)
            return m_mem[idx];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_instr",      bus.instr,               model_instr());
            chk("m_words",      32'(bus.words_loaded),   32'(m_count));
            chk("m_load_ready", 32'(bus.load_ready),     32'(m_mode == 0));
            chk("m_cpu_run",    32'(bus.cpu_run),        32'(m_mode == 1));
            chk("m_fetch_err",  32'(bus.fetch_err),      32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes_in [$]);
        for (int i = 0; i < bytes_in.size(); i++)
            send(bytes_in[i], (i == bytes_in.size() - 1) ? 1'b1 : 1'b0);
    endtask

    task automatic peek(input string name, input logic [7:0] pc_v, input logic [31:0] exp);
        bus.pc = pc_v;
        #1;
        chk(name, bus.instr, exp);
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
    endtask

    initial begin
        bus.pc         = 8'h00;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        bus.reload     = 1'b0;
        check_en       = 1'b1;
        tick();
        tick();
        chk("rst_words",      32'(bus.words_loaded), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready),   32'd1);
        chk("rst_cpu_run",    32'(bus.cpu_run),      32'd0);
        chk("rst_instr",      bus.instr,             32'h0);
        rst_n = 1'b1;
        tick();

        // Full two-word load
        send_list('{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20});
        chk("full_words",   32'(bus.words_loaded), 32'd2);
        chk("full_cpu_run", 32'(bus.cpu_run),      32'd1);
        peek("full_pc0", 8'h00, 32'h2008_0005);
        peek("full_pc4", 8'h04, 32'h0109_5020);
        peek("full_pc8", 8'h08, 32'h0000_0000);
        tick();

        // Misaligned fetch
        peek("mis_instr", 8'h06, 32'h0000_0000);
        tick();
        bus.pc = 8'h00;
        #1;
        chk("mis_err",     32'(bus.fetch_err), 32'd1);
        chk("mis_cpu_run", 32'(bus.cpu_run),   32'd1);
        tick();

        // Reload with a simultaneous byte that must be dropped
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h55;
        do_reload();
        bus.load_valid = 1'b0;
        chk("rel_err",   32'(bus.fetch_err),    32'd0);
        chk("rel_words", 32'(bus.words_loaded), 32'd0);
        send_list('{8'hDE, 8'hAD, 8'hBE, 8'hEF});
        chk("rel_words1", 32'(bus.words_loaded), 32'd1);
        peek("rel_pc0", 8'h00, 32'hDEAD_BEEF);
        peek("rel_pc4", 8'h04, 32'h0000_0000);
        tick();

        // Partial last word
        do_reload();
        send_list('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22});
        chk("part_words", 32'(bus.words_loaded), 32'd2);
        peek("part_pc0", 8'h00, 32'hAABB_CCDD);
        peek("part_pc4", 8'h04, 32'h1122_0000);
        tick();

        // Single last byte at byte count 0
        do_reload();
        send_list('{8'h7F});
        chk("one_words", 32'(bus.words_loaded), 32'd1);
        peek("one_pc0", 8'h00, 32'h7F00_0000);
        tick();

        // Async reset between edges, mid-word
        do_reload();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        chk("arst_pre_words", 32'(bus.words_loaded), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_words",      32'(bus.words_loaded), 32'd0);
        chk("arst_load_ready", 32'(bus.load_ready),   32'd1);
        chk("arst_cpu_run",    32'(bus.cpu_run),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_list('{8'h12, 8'h34, 8'h56, 8'h78});
        chk("arst_words1", 32'(bus.words_loaded), 32'd1);
        peek("arst_pc0", 8'h00, 32'h1234_5678);
        tick();

        // Overflow
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 256; i++)
            send(8'(i), 1'b0);
        chk("ovf_words64", 32'(bus.words_loaded), 32'd64);
        chk("ovf_ready64", 32'(bus.load_ready),   32'd1);
        send(8'hFF, 1'b0);
        chk("ovf_words",   32'(bus.words_loaded), 32'd64);
        chk("ovf_err",     32'(bus.fetch_err),    32'd1);
        chk("ovf_ready",   32'(bus.load_ready),   32'd0);
        chk("ovf_cpu_run", 32'(bus.cpu_run),      32'd0);
        peek("ovf_instr", 8'h00, 32'h0000_0000);

        // ERR ignores reload and bytes
        bus.load_valid = 1'b1;
        do_reload();
        bus.load_valid = 1'b0;
        tick();
        chk("err_stay_ready", 32'(bus.load_ready), 32'd0);
        chk("err_stay_err",   32'(bus.fetch_err),  32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("final_rst_err",   32'(bus.fetch_err),  32'd0);
        chk("final_rst_ready", 32'(bus.load_ready), 32'd1);
        tick();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
